// File: rtl/dsp_add_pipe.sv
// Elastic two-stage add/sub unit modelled on the DSP48 AREG/BREG -> PREG path.
// Valid/ready on both sides; results wrap modulo 2^width and carry a signed-overflow flag.
module dsp_add_pipe #(
   parameter int width = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] y,
   output logic             ovf
);

   logic             s1_valid;
   logic             s1_op;
   logic [width-1:0] s1_a;
   logic [width-1:0] s1_b;
   logic             s2_valid;

   logic             s1_adv;
   logic             s2_adv;
   logic [width-1:0] b_eff;
   logic [width-1:0] t;
   logic             t_ovf;

   // Advance terms ripple backwards from the consumer, so in_ready never depends on in_valid.
   always_comb begin
      s2_adv   = ~s2_valid | out_ready;
      s1_adv   = ~s1_valid | s2_adv;
      in_ready = reset & s1_adv;
   end

   // Subtraction is a + ~b + 1; overflow only when both effective operands share a sign
   // and the result's sign differs from it.
   always_comb begin
      b_eff = s1_op ? ~s1_b : s1_b;
      t     = s1_a + b_eff + {{(width-1){1'b0}}, s1_op};
      t_ovf = (s1_a[width-1] == b_eff[width-1]) & (t[width-1] != s1_a[width-1]);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values and the two stages shift together without ordering races.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_op    <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op <= op;
            s1_a  <= a;
            s1_b  <= b;
         end
      end
   end

   // y/ovf only move when a real result enters S2, so they hold their last value when empty.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         y        <= '0;
         ovf      <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            y   <= t;
            ovf <= t_ovf;
         end
      end
   end

   assign out_valid = s2_valid;

endmodule

// File: tb/tb_dsp_add_pipe.sv
// Directed bench for dsp_add_pipe: driver pushes hand-computed results into a queue,
// an independent monitor pops and compares on every output transfer.
module tb_dsp_add_pipe;

   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         op = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] y;
   logic         ovf;

   int           n_checks = 0;
   int           n_fail = 0;
   int           cyc = 0;
   logic [W:0]   exp_q[$];
   int           xfer_cyc[$];

   dsp_add_pipe #(.width(W)) dut (
      .clock    (clock),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .y        (y),
      .ovf      (ovf)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: samples just before each rising edge, after all drivers have settled.
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_y = '0;
   logic         prev_ovf = 1'b0;
   always begin
      logic [W:0] e;
      @(negedge clock);
      #2;
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_y", y, prev_y);
            check("hold_ovf", ovf, prev_ovf);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out_valid", out_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("y", y, e[W-1:0]);
               check("ovf", ovf, e[W]);
               xfer_cyc.push_back(cyc);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_y     = y;
         prev_ovf   = ovf;
      end
   end

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                       input logic [W-1:0] ey, input logic eo, input bit must_be_ready);
      int n = 0;
      @(negedge clock);
      a = ta;
      b = tb_v;
      op = top;
      in_valid = 1'b1;
      #1;
      if (must_be_ready) check("in_ready_b2b", in_ready, 1);
      while (!in_ready && n < 50) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (!in_ready) check("accept_timeout", in_ready, 1);
      exp_q.push_back({eo, ey});
      @(posedge clock);
   endtask

   task automatic idle();
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      #3;
      check("drain_pending", exp_q.size(), 0);
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         op;
      logic [W-1:0] y;
      logic         ovf;
   } vec_t;

   vec_t b2b[8] = '{
      '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0},
      '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0},
      '{8'h40, 8'h40, 1'b0, 8'h80, 1'b1},
      '{8'hF0, 8'h20, 1'b0, 8'h10, 1'b0},
      '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0},
      '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1},
      '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b1},
      '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0}
   };

   initial begin
      int base;

      // Reset state
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_y", y, 0);
      check("rst_ovf", ovf, 0);
      @(negedge clock);
      reset = 1'b1;
      out_ready = 1'b1;
      #1;
      check("in_ready_after_release", in_ready, 1);

      // Single beat latency: wrap-around add, carry discarded
      send(8'hFF, 8'h10, 1'b0, 8'h0F, 1'b0, 1'b1);
      idle();
      #1;
      check("lat_after_accept_edge", out_valid, 0);
      @(negedge clock);
      #1;
      check("lat_after_second_edge", out_valid, 1);
      @(negedge clock);
      #3;
      check("lat_drained", out_valid, 0);

      // Arithmetic corner cases
      send(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
      send(8'h00, 8'h80, 1'b1, 8'h80, 1'b1, 1'b0);
      send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0);
      send(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);
      idle();
      wait_drain();

      // Back-to-back throughput
      base = xfer_cyc.size();
      foreach (b2b[i]) send(b2b[i].a, b2b[i].b, b2b[i].op, b2b[i].y, b2b[i].ovf, 1'b1);
      idle();
      wait_drain();
      check("b2b_count", xfer_cyc.size() - base, 8);
      if (xfer_cyc.size() - base == 8)
         check("b2b_consecutive", xfer_cyc[base+7] - xfer_cyc[base], 7);

      // Back-pressure: two fill the pipe, third waits
      out_ready = 1'b0;
      send(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
      send(8'h02, 8'h02, 1'b0, 8'h04, 1'b0, 1'b1);
      @(negedge clock);
      a = 8'h03;
      b = 8'h03;
      op = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clock);
         #1;
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid", out_valid, 1);
         check("stall_y", y, 8'h02);
      end
      @(negedge clock);
      out_ready = 1'b1;
      #1;
      check("release_in_ready", in_ready, 1);
      exp_q.push_back({1'b0, 8'h06});
      @(posedge clock);
      idle();
      wait_drain();

      // Reset mid-flight with two results held
      out_ready = 1'b0;
      send(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
      send(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
      idle();
      #3;
      reset = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_y", y, 0);
      check("midrst_ovf", ovf, 0);
      exp_q.delete();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      out_ready = 1'b1;
      #1;
      check("post_rst_out_valid", out_valid, 0);
      send(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b1);
      idle();
      wait_drain();
      repeat (2) @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
